memory_shuffle: RTL and testbench
=================================

MEMORY_SHUFFLE -- requirements
Module: memory_shuffle

Interface
REQ-001 Parameter KEY_LENGTH, default 3: number of secret-key bytes used cyclically.
REQ-002 Port clk  input  1: single clock; all state changes on its rising edge.
REQ-003 Port reset_n  input  1: asynchronous, active-low reset.
REQ-004 Port start  input  1: request to run one full shuffle pass; sampled only in IDLE.
REQ-005 Port secret_key  input  8*KEY_LENGTH: key bytes. key[0] = most-significant byte; key[k] = secret_key[8*(KEY_LENGTH-1-k)+7 : 8*(KEY_LENGTH-1-k)].
REQ-006 Port address  output  8: S-memory address.
REQ-007 Port data  output  8: S-memory write data.
REQ-008 Port wren  output  1: S-memory write enable.
REQ-009 Port q  input  8: S-memory read data; valid in the cycle after the address was presented (1-cycle latency).
REQ-010 Port finish  output  1: single-cycle pulse marking completion of the pass.

Function
REQ-011 The block SHALL run after memory_write has left S[i]=i: for i=0..255: j = (j + S[i] + key[i mod KEY_LENGTH]) mod 256, then swap S[i] and S[j].
REQ-012 States: IDLE, RD_I, GET_I, RD_J, GET_J, WR_I, WR_J, DONE; one cycle each except IDLE.
REQ-013 IDLE: outputs idle; if start=1 at the edge, clear i, j and key index to 0 and go to RD_I; otherwise stay.
REQ-014 RD_I: address=i, wren=0.
REQ-015 GET_I: latch si=q; j <= j + q + key[kidx], truncated to 8 bits (wrap-around, no carry kept).
REQ-016 RD_J: address=j (new value), wren=0.
REQ-017 GET_J: latch sj=q.
REQ-018 WR_I: address=i, data=sj, wren=1.
REQ-019 WR_J: address=j, data=si, wren=1; then if i=255 go to DONE, else increment i and go to RD_I.
REQ-020 The key index SHALL be a counter 0..KEY_LENGTH-1 that wraps to 0 and advances with i; no divider.
REQ-021 If i=j, both writes carry the same value; S SHALL remain unchanged at that location.
REQ-022 Each iteration SHALL take exactly 6 cycles; a full pass SHALL take 1536 cycles from RD_I of i=0 to the end of WR_J of i=255.
REQ-023 DONE: finish=1 for exactly one cycle, wren=0; then go to IDLE.
REQ-024 start SHALL be ignored outside IDLE; if start is still high in IDLE after DONE, a new pass begins.
REQ-025 wren SHALL be 1 only in WR_I and WR_J; address and data SHALL be 0 whenever they are not driven by a state above.
REQ-026 secret_key SHALL be held stable by its source for the whole pass; the block does not register it.

Reset
REQ-027 reset_n=0 SHALL immediately force IDLE, i=0, j=0, key index 0, si=0, sj=0, address=0, data=0, wren=0, finish=0, independent of clk.
REQ-028 If reset_n is asserted mid-pass, the pass SHALL be aborted with no further writes; the next accepted start SHALL restart from i=0, j=0.

Verification
REQ-029 Bench model: 256x8 memory with 1-cycle read latency, preloaded with S[i]=i; result checked against a reference loop after finish.
REQ-030 Key 24'h000000, start pulsed 1 cycle -> first six writes (addr,data) are (0,0),(0,0),(1,1),(1,1),(2,3),(3,2).
REQ-031 Key 24'h0A0000 -> first two writes are (0,10),(10,0); finish pulses once, exactly 1537 cycles after the edge that sampled start.
REQ-032 Key 24'hFFFFFF -> j wraps on the first iteration (j=0+0+255=255): writes (0,255),(255,0); final S matches the reference, and S is a permutation of 0..255.
REQ-033 reset_n=0 during iteration 100 -> wren=0, finish=0 and address=0 without a clock edge; no writes until the next start; the rerun from a fresh S[i]=i preload matches the reference.
REQ-034 start toggled high during a pass, and start held high across DONE -> mid-pass start has no effect; held start launches a second pass immediately after DONE; finish never exceeds 1 cycle.

Source files
------------

// File: rtl/memory_shuffle.sv
// Key-scheduling shuffle over a 256-byte S memory with 1-cycle read latency.
// One iteration reads S[i] and S[j], then writes them back swapped; six cycles per i.
module memory_shuffle #(
  parameter int KEY_LENGTH = 3
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [8*KEY_LENGTH-1:0] secret_key,
  output logic [7:0]              address,
  output logic [7:0]              data,
  output logic                    wren,
  input  logic [7:0]              q,
  output logic                    finish
);

  localparam int KW = (KEY_LENGTH > 1) ? $clog2(KEY_LENGTH) : 1;

  typedef enum logic [2:0] {
    IDLE, RD_I, GET_I, RD_J, GET_J, WR_I, WR_J, DONE
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [7:0]      r_i;
  logic [7:0]      r_j;
  logic [7:0]      r_si;
  logic [7:0]      r_sj;
  logic [KW-1:0]   r_kidx;
  logic [7:0]      w_key [KEY_LENGTH];
  logic [7:0]      w_key_byte;

  // key[0] is the most-significant byte of secret_key
  genvar gi;
  generate
    for (gi = 0; gi < KEY_LENGTH; gi++) begin : g_key
      assign w_key[gi] = secret_key[8*(KEY_LENGTH-1-gi) +: 8];
    end
  endgenerate

  assign w_key_byte = w_key[r_kidx];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_i     <= 8'd0;
      r_j     <= 8'd0;
      r_si    <= 8'd0;
      r_sj    <= 8'd0;
      r_kidx  <= '0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_i    <= 8'd0;
            r_j    <= 8'd0;
            r_kidx <= '0;
          end
        end
        GET_I: begin
          r_si <= q;
          r_j  <= r_j + q + w_key_byte;
        end
        GET_J: r_sj <= q;
        WR_J: begin
          // key index runs alongside i as a wrapping counter instead of i mod KEY_LENGTH
          if (r_i != 8'hFF) begin
            r_i    <= r_i + 8'd1;
            r_kidx <= (r_kidx == KW'(KEY_LENGTH-1)) ? '0 : r_kidx + KW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_state_next = r_state;
    address      = 8'd0;
    data         = 8'd0;
    wren         = 1'b0;
    finish       = 1'b0;
    case (r_state)
      IDLE:  if (start) w_state_next = RD_I;
      RD_I: begin
        address      = r_i;
        w_state_next = GET_I;
      end
      GET_I: w_state_next = RD_J;
      RD_J: begin
        address      = r_j;
        w_state_next = GET_J;
      end
      GET_J: w_state_next = WR_I;
      WR_I: begin
        address      = r_i;
        data         = r_sj;
        wren         = 1'b1;
        w_state_next = WR_J;
      end
      WR_J: begin
        address      = r_j;
        data         = r_si;
        wren         = 1'b1;
        w_state_next = (r_i == 8'hFF) ? DONE : RD_I;
      end
      DONE: begin
        finish       = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_memory_shuffle.sv
// Directed bench for memory_shuffle: 256x8 S memory model with 1-cycle read latency
// and a reference shuffle loop for the final memory contents.
module tb_memory_shuffle;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [23:0] secret_key = 24'h0;
  logic [7:0]  address;
  logic [7:0]  data;
  logic [7:0]  q;
  logic        wren;
  logic        finish;

  int errors = 0;
  int checks = 0;

  memory_shuffle #(.KEY_LENGTH(3)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .secret_key (secret_key),
    .address    (address),
    .data       (data),
    .wren       (wren),
    .q          (q),
    .finish     (finish)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [256];
  logic       preload = 1'b0;
  logic       wr_clr = 1'b0;
  int         wr_cnt = 0;
  logic [7:0] wr_a [8];
  logic [7:0] wr_d [8];

  always @(posedge clk) begin
    q <= mem[address];
    if (preload) begin
      for (int a = 0; a < 256; a++) mem[a] <= 8'(a);
    end else if (wren) begin
      mem[address] <= data;
    end
    if (wr_clr) begin
      wr_cnt <= 0;
    end else if (wren) begin
      if (wr_cnt < 8) begin
        wr_a[wr_cnt] <= address;
        wr_d[wr_cnt] <= data;
      end
      wr_cnt <= wr_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  logic [7:0] ref_s [256];

  task automatic ref_init();
    for (int a = 0; a < 256; a++) ref_s[a] = 8'(a);
  endtask

  task automatic ref_pass(input logic [23:0] key);
    logic [7:0] j, t, kb;
    j = 8'd0;
    for (int i = 0; i < 256; i++) begin
      kb = key[8*(2 - (i % 3)) +: 8];
      j = j + ref_s[i] + kb;
      t = ref_s[i];
      ref_s[i] = ref_s[j];
      ref_s[j] = t;
    end
  endtask

  task automatic do_preload();
    @(negedge clk);
    preload = 1'b1;
    wr_clr  = 1'b1;
    @(negedge clk);
    preload = 1'b0;
    wr_clr  = 1'b0;
  endtask

  task automatic launch();
    @(negedge clk);
    check("idle_finish", 32'(finish), 0);
    start = 1'b1;
    @(posedge clk);
  endtask

  // k counts negedges after the edge that sampled start; returns -1 on timeout
  task automatic wait_finish(input int limit, input bit hold, input int tlo, input int thi,
                             output int fin_k);
    fin_k = -1;
    for (int k = 1; k <= limit; k++) begin
      @(negedge clk);
      start = hold || (k >= tlo && k <= thi);
      if (finish) begin
        fin_k = k;
        break;
      end
    end
  endtask

  task automatic compare_mem(input string tag);
    int bad;
    bad = 0;
    for (int a = 0; a < 256; a++) if (mem[a] !== ref_s[a]) bad++;
    check(tag, 32'(bad), 0);
  endtask

  task automatic check_writes(input string tag, input int n,
                              input logic [7:0] ea [6], input logic [7:0] ed [6]);
    for (int w = 0; w < n; w++) begin
      check($sformatf("%s_addr%0d", tag, w), 32'(wr_a[w]), 32'(ea[w]));
      check($sformatf("%s_data%0d", tag, w), 32'(wr_d[w]), 32'(ed[w]));
    end
  endtask

  initial begin
    int fk, wc, dups;
    int seen [256];
    logic [7:0] ea [6];
    logic [7:0] ed [6];

    repeat (3) @(negedge clk);
    check("rst_address", 32'(address), 0);
    check("rst_data", 32'(data), 0);
    check("rst_wren", 32'(wren), 0);
    check("rst_finish", 32'(finish), 0);
    reset_n = 1'b1;

    // key 0: identity-ish start of the shuffle
    secret_key = 24'h000000;
    do_preload(); ref_init(); ref_pass(secret_key);
    launch(); wait_finish(2000, 1'b0, 0, 0, fk);
    $display("pass key=%h finish_k=%0d writes=%0d", secret_key, fk, wr_cnt);
    check("k0_finish_k", 32'(fk), 1537);
    check("k0_writes", 32'(wr_cnt), 512);
    ea = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd2, 8'd3};
    ed = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd3, 8'd2};
    check_writes("k0", 6, ea, ed);
    compare_mem("k0_final");

    // key 0A0000
    secret_key = 24'h0A0000;
    do_preload(); ref_init(); ref_pass(secret_key);
    launch(); wait_finish(2000, 1'b0, 0, 0, fk);
    $display("pass key=%h finish_k=%0d writes=%0d", secret_key, fk, wr_cnt);
    check("k0a_finish_k", 32'(fk), 1537);
    ea = '{8'd0, 8'd10, 8'd0, 8'd0, 8'd0, 8'd0};
    ed = '{8'd10, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    check_writes("k0a", 2, ea, ed);
    compare_mem("k0a_final");
    @(negedge clk);
    check("k0a_finish_width", 32'(finish), 0);

    // key FFFFFF: j wraps on the first iteration
    secret_key = 24'hFFFFFF;
    do_preload(); ref_init(); ref_pass(secret_key);
    launch(); wait_finish(2000, 1'b0, 0, 0, fk);
    $display("pass key=%h finish_k=%0d writes=%0d", secret_key, fk, wr_cnt);
    check("kff_finish_k", 32'(fk), 1537);
    ea = '{8'd0, 8'd255, 8'd0, 8'd0, 8'd0, 8'd0};
    ed = '{8'd255, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    check_writes("kff", 2, ea, ed);
    compare_mem("kff_final");
    for (int a = 0; a < 256; a++) seen[a] = 0;
    for (int a = 0; a < 256; a++) seen[mem[a]]++;
    dups = 0;
    for (int a = 0; a < 256; a++) if (seen[a] != 1) dups++;
    check("kff_permutation", 32'(dups), 0);

    // asynchronous reset during WR_I of iteration 100
    secret_key = 24'h0A0000;
    do_preload();
    launch();
    for (int k = 1; k <= 605; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("it100_wren", 32'(wren), 1);
    check("it100_addr", 32'(address), 100);
    #2 reset_n = 1'b0;
    #1;
    check("arst_wren", 32'(wren), 0);
    check("arst_address", 32'(address), 0);
    check("arst_data", 32'(data), 0);
    check("arst_finish", 32'(finish), 0);
    wc = wr_cnt;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    check("arst_no_writes", 32'(wr_cnt), 32'(wc));
    $display("reset key=%h writes_before_reset=%0d", secret_key, wc);
    do_preload(); ref_init(); ref_pass(secret_key);
    launch(); wait_finish(2000, 1'b0, 0, 0, fk);
    $display("pass key=%h finish_k=%0d writes=%0d", secret_key, fk, wr_cnt);
    check("rerun_finish_k", 32'(fk), 1537);
    compare_mem("rerun_final");

    // start pulsed mid-pass is ignored
    secret_key = 24'h123456;
    do_preload(); ref_init(); ref_pass(secret_key);
    launch(); wait_finish(2000, 1'b0, 500, 502, fk);
    $display("pass key=%h finish_k=%0d writes=%0d", secret_key, fk, wr_cnt);
    check("tog_finish_k", 32'(fk), 1537);
    repeat (20) @(negedge clk);
    check("tog_writes", 32'(wr_cnt), 512);
    compare_mem("tog_final");

    // start held across DONE launches a second pass right away
    secret_key = 24'h010203;
    do_preload(); ref_init(); ref_pass(secret_key); ref_pass(secret_key);
    launch(); wait_finish(2000, 1'b1, 0, 0, fk);
    check("hold1_finish_k", 32'(fk), 1537);
    launch(); wait_finish(2000, 1'b1, 0, 0, fk);
    check("hold2_finish_k", 32'(fk), 1537);
    @(negedge clk);
    start = 1'b0;
    check("hold_finish_width", 32'(finish), 0);
    repeat (10) @(negedge clk);
    $display("pass key=%h held start, writes=%0d", secret_key, wr_cnt);
    check("hold_writes", 32'(wr_cnt), 1024);
    compare_mem("hold_final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
